// File: rtl/fp16_pkg.sv
// Shared fp16 field layout, special encodings and classification helpers.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  // All-ones exponent marks Inf/NaN.
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 5'(2 * BIAS + 1);

  localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
  localparam logic [15:0] FP16_QNAN     = 16'h7E00;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp16_t;

  function automatic logic is_nan(input fp16_t v);
    return (v.exp == EXP_SPECIAL) && (v.man != {MAN_W{1'b0}});
  endfunction

  function automatic logic is_inf(input fp16_t v);
    return (v.exp == EXP_SPECIAL) && (v.man == {MAN_W{1'b0}});
  endfunction

  // Leading-zero count of a 14-bit vector; 14 when the vector is zero.
  function automatic logic [3:0] lzc14(input logic [13:0] v);
    logic [3:0] n;
    n = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (v[i]) begin
        n = 4'(13 - i);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp16_add.sv
// Combinational fp16 adder: subnormals flushed to zero, round-to-nearest-even,
// canonical qNaN, overflow to signed infinity, cancellation to +0.
module fp16_add
  import fp16_pkg::*;
(
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] sum_o
);

  fp16_t              a_s, b_s, big_s, small_s;
  logic [4:0]         exp_diff_s;
  logic [26:0]        small_full_s;
  logic [13:0]        big_al_s, small_al_s, norm_s;
  logic [14:0]        raw_s;
  logic [3:0]         lz_s;
  logic [11:0]        mant_r_s;
  logic [9:0]         frac_s;
  logic               rnd_up_s;
  logic signed [6:0]  exp_big_s, exp_n_s, exp_r_s;
  logic [15:0]        norm_res_s;

  assign a_s = a_i;
  assign b_s = b_i;

  // Finite datapath: align the smaller magnitude, add/sub, normalise, round.
  always_comb begin
    if ({b_s.exp, b_s.man} > {a_s.exp, a_s.man}) begin
      big_s   = b_s;
      small_s = a_s;
    end else begin
      big_s   = a_s;
      small_s = b_s;
    end
    exp_diff_s   = big_s.exp - small_s.exp;
    // 16 spare bits below the mantissa keep guard/round exact; the rest folds into sticky.
    small_full_s = {1'b1, small_s.man, 16'h0000} >> exp_diff_s;
    small_al_s   = {small_full_s[26:14], |small_full_s[13:0]};
    big_al_s     = {1'b1, big_s.man, 3'b000};
    if (big_s.sign ^ small_s.sign) begin
      raw_s = {1'b0, big_al_s} - {1'b0, small_al_s};
    end else begin
      raw_s = {1'b0, big_al_s} + {1'b0, small_al_s};
    end
    exp_big_s = signed'({2'b00, big_s.exp});
    lz_s      = lzc14(raw_s[13:0]);
    if (raw_s[14]) begin
      norm_s  = {raw_s[14:2], raw_s[1] | raw_s[0]};
      exp_n_s = exp_big_s + 7'sd1;
    end else begin
      norm_s  = raw_s[13:0] << lz_s;
      exp_n_s = exp_big_s - signed'({3'b000, lz_s});
    end
    rnd_up_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
    mant_r_s = {1'b0, norm_s[13:3]} + {11'd0, rnd_up_s};
    if (mant_r_s[11]) begin
      exp_r_s = exp_n_s + 7'sd1;
      frac_s  = mant_r_s[10:1];
    end else begin
      exp_r_s = exp_n_s;
      frac_s  = mant_r_s[9:0];
    end
    if (raw_s == 15'd0) begin
      norm_res_s = FP16_POS_ZERO;
    end else if (exp_r_s >= signed'({2'b00, EXP_SPECIAL})) begin
      norm_res_s = big_s.sign ? FP16_NEG_INF : FP16_POS_INF;
    end else if (exp_r_s <= 7'sd0) begin
      norm_res_s = FP16_POS_ZERO;
    end else begin
      norm_res_s = {big_s.sign, exp_r_s[4:0], frac_s};
    end
  end

  // Special-operand selection ahead of the finite datapath result.
  always_comb begin
    if (is_nan(a_s) || is_nan(b_s) ||
        (is_inf(a_s) && is_inf(b_s) && (a_s.sign != b_s.sign))) begin
      sum_o = FP16_QNAN;
    end else if (is_inf(a_s)) begin
      sum_o = a_s;
    end else if (is_inf(b_s)) begin
      sum_o = b_s;
    end else if ((a_s.exp == 5'd0) && (b_s.exp == 5'd0)) begin
      sum_o = {a_s.sign & b_s.sign, 15'd0};
    end else if (a_s.exp == 5'd0) begin
      sum_o = b_s;
    end else if (b_s.exp == 5'd0) begin
      sum_o = a_s;
    end else begin
      sum_o = norm_res_s;
    end
  end

endmodule

// File: rtl/fp16_accumulator.sv
// Streaming fp16 accumulator: running sum per accepted sample, cleared after tlast,
// results delivered through a LATENCY-deep output pipeline.
module fp16_accumulator
  import fp16_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        s_axis_a_tvalid,
  input  logic [15:0] s_axis_a_tdata,
  input  logic        s_axis_a_tlast,
  output logic        m_axis_result_tvalid,
  output logic [15:0] m_axis_result_tdata,
  output logic        m_axis_result_tlast
);

  logic [15:0]               acc_q, acc_d, sum_s;
  logic [LATENCY-1:0]        vld_q, vld_d, last_q, last_d;
  logic [LATENCY-1:0][15:0]  data_q, data_d;

  fp16_add u_add (
    .a_i   (acc_q),
    .b_i   (s_axis_a_tdata),
    .sum_o (sum_s)
  );

  // Next accumulator value and pipeline shift; idle slots carry zero data.
  always_comb begin
    acc_d  = acc_q;
    vld_d  = vld_q;
    last_d = last_q;
    data_d = data_q;
    if (s_axis_a_tvalid) begin
      if (s_axis_a_tlast) begin
        acc_d = FP16_POS_ZERO;
      end else begin
        acc_d = sum_s;
      end
      data_d[0] = sum_s;
    end else begin
      acc_d     = acc_q;
      data_d[0] = 16'h0000;
    end
    vld_d[0]  = s_axis_a_tvalid;
    last_d[0] = s_axis_a_tvalid & s_axis_a_tlast;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
      data_d[i] = data_q[i-1];
    end
  end

  // Accumulator and output pipeline registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc_q  <= FP16_POS_ZERO;
      vld_q  <= {LATENCY{1'b0}};
      last_q <= {LATENCY{1'b0}};
      data_q <= {LATENCY{16'h0000}};
    end else begin
      acc_q  <= acc_d;
      vld_q  <= vld_d;
      last_q <= last_d;
      data_q <= data_d;
    end
  end

  assign m_axis_result_tvalid = vld_q[LATENCY-1];
  assign m_axis_result_tdata  = data_q[LATENCY-1];
  assign m_axis_result_tlast  = last_q[LATENCY-1];

endmodule

// File: tb/tb_fp16_accumulator.sv
// Self-checking bench for fp16_accumulator: directed vector table, reset sequence,
// and randomized traffic against an exact-integer fp16 reference model.
module tb_fp16_accumulator;

  localparam int LAT = 2;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        ev;
    logic [15:0] ed;
    logic        el;
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = 16'h0000;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_last;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [17:0] exp_pipe [LAT];
  logic [15:0] acc_m = 16'h0000;
  vec_t        tbl [$];

  fp16_accumulator #(.LATENCY(LAT)) dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .s_axis_a_tvalid      (s_valid),
    .s_axis_a_tdata       (s_data),
    .s_axis_a_tlast       (s_last),
    .m_axis_result_tvalid (m_valid),
    .m_axis_result_tdata  (m_data),
    .m_axis_result_tlast  (m_last)
  );

  always #5 aclk = ~aclk;

  // Signed value of a finite fp16 in units of 2^-24 (subnormals read as zero).
  function automatic longint fp_val(input logic [15:0] x);
    longint m;
    if (x[14:10] == 5'd0) return 64'sd0;
    m = longint'({1'b1, x[9:0]}) <<< (int'(x[14:10]) - 1);
    return x[15] ? -m : m;
  endfunction

  // Reference fp16 addition: exact integer sum, then round-to-nearest-even.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic        a_sp, b_sp, sgn;
    longint      s;
    logic [63:0] mag, keep, rem, half;
    int          p, sh, e;
    a_sp = (a[14:10] == 5'd31);
    b_sp = (b[14:10] == 5'd31);
    if ((a_sp && a[9:0] != 10'd0) || (b_sp && b[9:0] != 10'd0)) return 16'h7E00;
    if (a_sp && b_sp) return (a[15] == b[15]) ? a : 16'h7E00;
    if (a_sp) return a;
    if (b_sp) return b;
    if (fp_val(a) == 64'sd0 && fp_val(b) == 64'sd0) return {a[15] & b[15], 15'd0};
    s = fp_val(a) + fp_val(b);
    if (s == 64'sd0) return 16'h0000;
    sgn = (s < 64'sd0);
    mag = sgn ? 64'(-s) : 64'(s);
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    if (p < 10) return 16'h0000;
    sh = p - 10;
    keep = mag >> sh;
    if (sh > 0) begin
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
    end
    e = p - 9;
    if (keep == 64'd2048) begin
      keep = 64'd1024;
      e = e + 1;
    end
    if (e >= 31) return sgn ? 16'hFC00 : 16'h7C00;
    return {sgn, 5'(e), keep[9:0]};
  endfunction

  function automatic logic [15:0] rand_fp();
    int unsigned k;
    k = $urandom_range(0, 99);
    if (k < 1)  return 16'h7C00;
    if (k < 2)  return 16'hFC00;
    if (k < 3)  return {1'b0, 5'd31, 10'($urandom_range(1, 1023))};
    if (k < 6)  return {1'($urandom_range(0, 1)), 5'd0, 10'($urandom_range(1, 1023))};
    if (k < 10) return {1'($urandom_range(0, 1)), 15'h7BFF};
    if (k < 12) return 16'h0000;
    return {1'($urandom_range(0, 1)), 5'($urandom_range(11, 18)), 10'($urandom)};
  endfunction

  task automatic check_out(input string name, input logic [17:0] want);
    logic [17:0] got;
    got = {m_valid, m_data, m_last};
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got v=%0b d=%h l=%0b, want v=%0b d=%h l=%0b",
               name, got[17], got[16:1], got[0], want[17], want[16:1], want[0]);
    end
  endtask

  // One clock cycle: drive inputs, take the edge, compare output with the expected delay line.
  task automatic step(input logic v, input logic [15:0] d, input logic l,
                      input logic [17:0] exp_rec, input string name);
    s_valid = v;
    s_data  = d;
    s_last  = l;
    @(posedge aclk);
    for (int i = LAT - 1; i > 0; i--) exp_pipe[i] = exp_pipe[i-1];
    exp_pipe[0] = exp_rec;
    #1;
    check_out(name, exp_pipe[LAT-1]);
  endtask

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic l,
                              input logic [15:0] ed);
    return {v, d, l, v, v ? ed : 16'h0000, v & l};
  endfunction

  initial begin
    for (int i = 0; i < LAT; i++) exp_pipe[i] = 18'd0;

    // Reset state
    repeat (2) @(posedge aclk);
    #1;
    check_out("reset_state", 18'd0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Directed vectors
    tbl.push_back(mk(1'b1, 16'h0000, 1'b1, 16'h0000));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b1, 16'h3C00, 1'b0, 16'h3C00));
    tbl.push_back(mk(1'b1, 16'h3C00, 1'b0, 16'h4000));
    tbl.push_back(mk(1'b0, 16'h1234, 1'b1, 16'h0000));
    tbl.push_back(mk(1'b1, 16'h4000, 1'b0, 16'h4400));
    tbl.push_back(mk(1'b0, 16'h0000, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b1, 16'h4200, 1'b1, 16'h4700));
    tbl.push_back(mk(1'b1, 16'h3C00, 1'b0, 16'h3C00));
    tbl.push_back(mk(1'b1, 16'h4000, 1'b0, 16'h4200));
    tbl.push_back(mk(1'b1, 16'h4200, 1'b0, 16'h4600));
    tbl.push_back(mk(1'b1, 16'h4200, 1'b1, 16'h4880));
    tbl.push_back(mk(1'b1, 16'h4000, 1'b1, 16'h4000));
    tbl.push_back(mk(1'b1, 16'h7BFF, 1'b0, 16'h7BFF));
    tbl.push_back(mk(1'b1, 16'h7BFF, 1'b0, 16'h7C00));
    tbl.push_back(mk(1'b1, 16'h3C00, 1'b0, 16'h7C00));
    tbl.push_back(mk(1'b1, 16'hFC00, 1'b0, 16'h7E00));
    tbl.push_back(mk(1'b1, 16'h3C00, 1'b1, 16'h7E00));
    tbl.push_back(mk(1'b1, 16'h3C00, 1'b1, 16'h3C00));
    tbl.push_back(mk(1'b1, 16'h3C00, 1'b0, 16'h3C00));
    tbl.push_back(mk(1'b1, 16'hBC00, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b1, 16'h0001, 1'b0, 16'h0000));
    tbl.push_back(mk(1'b1, 16'h4000, 1'b0, 16'h4000));
    tbl.push_back(mk(1'b1, 16'h8001, 1'b1, 16'h4000));
    tbl.push_back(mk(1'b1, 16'h3C00, 1'b0, 16'h3C00));
    tbl.push_back(mk(1'b1, 16'h1000, 1'b0, 16'h3C00));
    tbl.push_back(mk(1'b1, 16'h1001, 1'b0, 16'h3C01));
    tbl.push_back(mk(1'b1, 16'h1000, 1'b1, 16'h3C02));
    tbl.push_back(mk(1'b1, 16'hFBFF, 1'b0, 16'hFBFF));
    tbl.push_back(mk(1'b1, 16'hFBFF, 1'b1, 16'hFC00));
    tbl.push_back(mk(1'b1, 16'h0401, 1'b0, 16'h0401));
    tbl.push_back(mk(1'b1, 16'h8400, 1'b1, 16'h0000));
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].l, {tbl[i].ev, tbl[i].ed, tbl[i].el},
           $sformatf("vec%0d", i));
    end

    // Reset in the middle of a group with results in flight
    step(1'b1, 16'h3C00, 1'b0, {1'b1, 16'h3C00, 1'b0}, "pre_rst0");
    step(1'b1, 16'h4000, 1'b0, {1'b1, 16'h4200, 1'b0}, "pre_rst1");
    s_valid = 1'b0;
    #2 aresetn = 1'b0;
    #1 check_out("rst_async", 18'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < LAT; i++) exp_pipe[i] = 18'd0;
    step(1'b1, 16'h4000, 1'b0, {1'b1, 16'h4000, 1'b0}, "post_rst0");
    step(1'b1, 16'h3C00, 1'b1, {1'b1, 16'h4200, 1'b1}, "post_rst1");
    step(1'b0, 16'h0000, 1'b0, 18'd0, "post_rst2");
    step(1'b0, 16'h0000, 1'b0, 18'd0, "post_rst3");

    // Randomized traffic against the reference model
    acc_m = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      logic        v, l;
      logic [15:0] d, s;
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 6) == 0);
      d = rand_fp();
      if (v) begin
        s = ref_add(acc_m, d);
        acc_m = l ? 16'h0000 : s;
        step(v, d, l, {1'b1, s, l}, "rand");
      end else begin
        step(v, d, l, 18'd0, "rand_idle");
      end
    end
    for (int i = 0; i < LAT; i++) step(1'b0, 16'h0000, 1'b0, 18'd0, "drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
